// File: rtl/alu_op_sequencer.sv
// Sequences one ALU command: read A (and B), execute, write back, pulse done.
// Latency 5/4/3 cycles accept-to-done (binary/unary/NOP); no backpressure, start ignored while busy.
module alu_op_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [2:0]  rs1,
  input  logic [2:0]  rs2,
  input  logic [2:0]  rd,
  output logic        busy,
  output logic        done,
  output logic [3:0]  flags,
  output logic [2:0]  pa,
  output logic        rdr,
  input  logic [15:0] p,
  output logic [2:0]  wp,
  output logic        wrr,
  output logic [15:0] wdata,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic [2:0]  alu_fsel,
  input  logic [15:0] alu_z,
  input  logic        alu_c,
  input  logic        alu_v,
  input  logic        alu_s,
  input  logic        alu_zd
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, WB, DONE} state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] rs2;
    logic [2:0] rd;
  } cmd_t;

  localparam logic [2:0] OP_NOP = 3'b101;

  state_t      state;
  cmd_t        cmd;
  logic [15:0] a_reg;
  logic [15:0] b_reg;
  logic [15:0] r_reg;

  // rs1 is only needed for the first read, so the pa register itself holds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cmd   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      rdr   <= 1'b0;
      wrr   <= 1'b0;
      flags <= 4'b0000;
      pa    <= 3'd0;
      wp    <= 3'd0;
      a_reg <= 16'd0;
      b_reg <= 16'd0;
      r_reg <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cmd   <= '{op: op, rs2: rs2, rd: rd};
            pa    <= rs1;
            rdr   <= 1'b1;
            busy  <= 1'b1;
            state <= RD_A;
          end
        end
        RD_A: begin
          a_reg <= p;
          if (cmd.op[2]) begin
            rdr   <= 1'b0;
            state <= EXEC;
          end else begin
            pa    <= cmd.rs2;
            state <= RD_B;
          end
        end
        RD_B: begin
          b_reg <= p;
          rdr   <= 1'b0;
          state <= EXEC;
        end
        EXEC: begin
          if (cmd.op == OP_NOP) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            r_reg <= alu_z;
            flags <= {alu_c, alu_v, alu_s, alu_zd};
            wp    <= cmd.rd;
            wrr   <= 1'b1;
            state <= WB;
          end
        end
        WB: begin
          wrr   <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          rdr   <= 1'b0;
          wrr   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign wdata    = r_reg;
  assign alu_x    = a_reg;
  assign alu_y    = b_reg;
  assign alu_fsel = cmd.op;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a register-file and ALU model around the DUT.
module tb_alu_op_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op, rs1, rs2, rd;
  logic        busy, done;
  logic [3:0]  flags;
  logic [2:0]  pa, wp;
  logic        rdr, wrr;
  logic [15:0] p, wdata;
  logic [15:0] alu_x, alu_y, alu_z;
  logic [2:0]  alu_fsel;
  logic        alu_c, alu_v, alu_s, alu_zd;

  int checks = 0;
  int errs   = 0;

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs1(rs1), .rs2(rs2), .rd(rd),
    .busy(busy), .done(done), .flags(flags), .pa(pa), .rdr(rdr), .p(p),
    .wp(wp), .wrr(wrr), .wdata(wdata), .alu_x(alu_x), .alu_y(alu_y),
    .alu_fsel(alu_fsel), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .alu_s(alu_s), .alu_zd(alu_zd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: r1=5 r2=3 r4=3 r5=7FFF r6=1.
  logic [15:0] regs [8] = '{16'h0000, 16'h0005, 16'h0003, 16'h0000,
                            16'h0003, 16'h7FFF, 16'h0001, 16'h0000};
  assign p = regs[pa];
  always @(posedge clk) if (wrr) regs[wp] <= wdata;

  // ALU model: 000 add, 001 sub (C = no borrow), 100 negate, others logic.
  logic [15:0] tz;
  logic        tc, tv;
  always_comb begin
    tz = 16'd0;
    tc = 1'b0;
    tv = 1'b0;
    case (alu_fsel)
      3'b000: begin
        {tc, tz} = {1'b0, alu_x} + {1'b0, alu_y};
        tv = (alu_x[15] == alu_y[15]) && (tz[15] != alu_x[15]);
      end
      3'b001: begin
        {tc, tz} = {1'b0, alu_x} + {1'b0, ~alu_y} + 17'd1;
        tv = (alu_x[15] != alu_y[15]) && (tz[15] != alu_x[15]);
      end
      3'b100: begin
        {tc, tz} = {1'b0, ~alu_x} + 17'd1;
        tv = (alu_x == 16'h8000);
      end
      3'b010:  tz = alu_x & alu_y;
      3'b011:  tz = alu_x | alu_y;
      3'b110:  tz = ~alu_x;
      default: tz = alu_x;
    endcase
  end
  assign alu_z  = tz;
  assign alu_c  = tc;
  assign alu_v  = tv;
  assign alu_s  = tz[15];
  assign alu_zd = (tz == 16'd0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_op(input logic [2:0] op_i, input logic [2:0] rs1_i,
                        input logic [2:0] rs2_i, input logic [2:0] rd_i, input bit hold,
                        output int lat, output int nwr,
                        output logic [2:0] wp_o, output logic [15:0] wd_o);
    start = 1'b1; op = op_i; rs1 = rs1_i; rs2 = rs2_i; rd = rd_i;
    @(posedge clk);
    if (!hold) #1 start = 1'b0;
    lat = 0; nwr = 0; wp_o = 3'd0; wd_o = 16'd0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (wrr) begin
        nwr++;
        wp_o = wp;
        wd_o = wdata;
      end
      if (done) begin
        lat = c;
        break;
      end
    end
    if (hold) begin
      @(posedge clk);
      #1 start = 1'b0;
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [2:0]  op, rs1, rs2, rd;
    logic [15:0] wd;
    logic [3:0]  fl;
    int          lat;
    int          nwr;
  } vec_t;

  vec_t        vecs [7];
  int          lat, nwr;
  logic [2:0]  wp_s;
  logic [15:0] wd_s;
  bit          saw_wb;

  initial begin
    vecs[0] = '{3'b000, 3'd1, 3'd2, 3'd3, 16'h0008, 4'b0000, 5, 1};
    vecs[1] = '{3'b001, 3'd1, 3'd2, 3'd7, 16'h0002, 4'b1000, 5, 1};
    vecs[2] = '{3'b001, 3'd2, 3'd1, 3'd7, 16'hFFFE, 4'b0010, 5, 1};
    vecs[3] = '{3'b000, 3'd5, 3'd6, 3'd3, 16'h8000, 4'b0110, 5, 1};
    vecs[4] = '{3'b100, 3'd4, 3'd0, 3'd4, 16'hFFFD, 4'b0010, 4, 1};
    vecs[5] = '{3'b001, 3'd1, 3'd1, 3'd7, 16'h0000, 4'b1001, 5, 1};
    vecs[6] = '{3'b101, 3'd1, 3'd2, 3'd6, 16'h0001, 4'b1001, 3, 0};

    rst_n = 1'b0; start = 1'b0; op = 3'd0; rs1 = 3'd0; rs2 = 3'd0; rd = 3'd0;
    #12;
    check("rst busy",  busy,  1'b0);
    check("rst done",  done,  1'b0);
    check("rst rdr",   rdr,   1'b0);
    check("rst wrr",   wrr,   1'b0);
    check("rst flags", flags, 4'b0000);
    check("rst pa",    pa,    3'd0);
    check("rst wp",    wp,    3'd0);
    check("rst wdata", wdata, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, 1'b0, lat, nwr, wp_s, wd_s);
      check($sformatf("v%0d latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d wr pulses", i), nwr, vecs[i].nwr);
      check($sformatf("v%0d flags", i), flags, vecs[i].fl);
      check($sformatf("v%0d dest reg", i), regs[vecs[i].rd], vecs[i].wd);
      if (vecs[i].nwr == 1) begin
        check($sformatf("v%0d wp", i), wp_s, vecs[i].rd);
        check($sformatf("v%0d wdata", i), wd_s, vecs[i].wd);
      end
    end

    // start held high across a whole operation, including its DONE cycle
    run_op(3'b000, 3'd1, 3'd2, 3'd3, 1'b1, lat, nwr, wp_s, wd_s);
    check("hold latency", lat, 5);
    check("hold wr pulses", nwr, 1);
    check("hold busy after", busy, 1'b0);
    @(negedge clk);
    check("hold still idle", busy, 1'b0);

    // reset pulsed while in WB: write must be aborted
    start = 1'b1; op = 3'b000; rs1 = 3'd1; rs2 = 3'd2; rd = 3'd5;
    @(posedge clk);
    #1 start = 1'b0;
    saw_wb = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (wrr) begin
        saw_wb = 1'b1;
        break;
      end
    end
    check("abort reached WB", saw_wb, 1'b1);
    check("abort WB busy", busy, 1'b1);
    check("abort WB wdata", wdata, 16'h0008);
    #2 rst_n = 1'b0;
    #1;
    check("abort wrr", wrr, 1'b0);
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort flags", flags, 4'b0000);
    @(posedge clk);
    @(negedge clk);
    check("abort dest", regs[5], 16'h7FFF);
    check("abort no done", done, 1'b0);
    rst_n = 1'b1;

    // first start after reset release is accepted on the first edge
    run_op(3'b000, 3'd1, 3'd2, 3'd6, 1'b0, lat, nwr, wp_s, wd_s);
    check("post-rst latency", lat, 5);
    check("post-rst wr pulses", nwr, 1);
    check("post-rst dest", regs[6], 16'h0008);
    check("post-rst flags", flags, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 The block SHALL have exactly one clock and one reset, with the reset asynchronous and active-low:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
REQ-002 The block SHALL have the following command ports:
- start  in  1  command request; sampled only in IDLE.
- op  in  3  ALU function code, passed to ALU fsel.
- rs1, rs2, rd  in  3 each  source A, source B and destination register indices.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- flags  out  4  {C,V,S,Z}, registered.
REQ-003 The block SHALL have the following register-bank ports:
- pa  out  3  read address.
- rdr  out  1  read enable.
- p  in  16  read data, valid in the same cycle rdr is high.
- wp  out  3  write address.
- wrr  out  1  write enable.
- wdata  out  16  write data.
REQ-004 The block SHALL have the following ALU ports:
- alu_x, alu_y  out  16 each  operands.
- alu_fsel  out  3  function select.
- alu_z  in  16  result.
- alu_c, alu_v, alu_s, alu_zd  in  1 each  flag outputs.

Function
REQ-005 The FSM SHALL have states IDLE, RD_A, RD_B, EXEC, WB, DONE.
REQ-006 In IDLE with start=1, the block SHALL capture op, rs1, rs2 and rd into internal registers and go to RD_A; start in any other state SHALL be ignored.
REQ-007 In RD_A, the block SHALL drive pa=rs1 and rdr=1, and SHALL load p into A_reg on the exiting edge.
REQ-008 From RD_A, the next state SHALL be RD_B if op[2]=0, and EXEC if op[2]=1 (unary ops 100/110/111); B_reg SHALL be held for unary ops.
REQ-009 In RD_B, the block SHALL drive pa=rs2 and rdr=1, and SHALL load p into B_reg, then go to EXEC.
REQ-010 In EXEC, the block SHALL drive alu_x=A_reg, alu_y=B_reg and alu_fsel=op; on the exiting edge it SHALL latch alu_z into R_reg and {alu_c,alu_v,alu_s,alu_zd} into flags.
REQ-011 Op 101 is reserved/NOP: EXEC SHALL go directly to DONE, R_reg and flags SHALL be unchanged, and no write SHALL occur.
REQ-012 In WB, the block SHALL drive wp=rd, wdata=R_reg and wrr=1 for exactly one cycle, then go to DONE.
REQ-013 In DONE, done SHALL be 1 for one cycle, then the FSM SHALL return to IDLE; a start in DONE SHALL be ignored.
REQ-014 Latency from the start-accept edge to done high SHALL be 5 cycles for binary ops, 4 for unary ops, and 3 for NOP.
REQ-015 Outside their states, rdr and wrr SHALL be 0; pa, wp and wdata SHALL hold their last values; alu_x, alu_y and alu_fsel SHALL be continuously driven from A_reg, B_reg and the captured op.
REQ-016 Register indices SHALL be used unmodified, so rd may equal rs1 or rs2: the read completes before WB, and the old value is used.
REQ-017 All arithmetic SHALL be performed by the ALU; the block SHALL not alter widths, and 16-bit wrap-around SHALL be passed through unchanged.

Reset
REQ-018 While rst_n=0, the block SHALL force: state=IDLE, busy=0, done=0, rdr=0, wrr=0, flags=4'b0000, pa=wp=0, wdata=0, and A_reg=B_reg=R_reg=0.
REQ-019 Assertion of rst_n mid-operation SHALL abort immediately, with no write (wrr=0 immediately, including in WB) and no done pulse.
REQ-020 After rst_n deasserts, the first start SHALL be accepted on the first rising edge.

Verification
REQ-021 The bench SHALL cover: r1=5, r2=3, op=000 (add), rd=r3 -> one wrr pulse with wp=3 and wdata=8, done at cycle 5, flags C=0 V=0 S=0.
REQ-022 The bench SHALL cover: r1=5, r2=3, op=001 (sub) -> wdata=2, C=1; then r1=3, r2=5, op=001 -> wdata=0xFFFE, S=1.
REQ-023 The bench SHALL cover: r1=0x7FFF, r2=1, op=000 -> wdata=0x8000, V=1, S=1.
REQ-024 The bench SHALL cover: r4=0x0003, op=100, rd=r4 -> RD_B skipped, wdata=0xFFFD written to r4, done at cycle 4.
REQ-025 The bench SHALL cover: start held high through an operation -> exactly one operation executes; op=101 -> no wrr pulse, flags unchanged, done at cycle 3.
REQ-026 The bench SHALL cover: rst_n pulsed low during WB -> wrr drops asynchronously, destination unchanged, busy=0 and flags=0 after reset.
